gl_cmd_sequencer: RTL and testbench
===================================

Name: gl_cmd_sequencer

Overview:
Parametrised successor to the GL command decoder, sitting between the command fetch stage and the matrix stack, matrix multiplier, perspective divider and BRAM.
- Replaces hard-coded stall counts with per-operation latency parameters.
- Adds a valid/ready command handshake, a synchronous reset, and single-cycle enable pulses.
- Adds a read-capture path shared by colour and viewport, plus done and illegal-opcode reporting.

Parameters:
ADDR_W, 32, BRAM address width
DATA_W, 32, float word width
MUL4_LAT, 13, cycles from matrix_mul_en pulse to 4x4 result ready (min 1)
MUL1_LAT, 3, cycles from matrix_mul_en pulse to 4x1 result ready (min 1)
PDIV_LAT, 1, perspective divide latency (min 1)
LOAD_WORDS, 4, BRAM reads per matrix load (four floats per read)
ADDR_STRIDE, 4, address increment between matrix-load reads

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept
opcode  in  8  GL opcode
imm  in  23  immediate; imm[0] = matrix mode
bram_addr_in  in  ADDR_W  operand base address
bram_rd_data  in  4*DATA_W  {w3,w2,w1,w0}, synchronous read, 1-cycle latency
bram_addr_out  out  ADDR_W  read address
bram_mux_sel  out  1  0 = sequencer drives BRAM address
viewport  out  4*DATA_W  {height,width,y,x}
color  out  3*DATA_W  {blue,green,red}
matrix_mode_out  out  1  0 modelview, 1 projection
matrix_mul_type  out  1  1 = 4x4*4x4, 0 = 4x4*4x1
matrix_mul_en, matrix_load_en, matrix_load_id_en, push_en, pop_en, perspective_div_en  out  1 each  enables
busy  out  1  not IDLE
cmd_done  out  1  1-cycle pulse at command completion
err_illegal  out  1  1-cycle pulse, unknown opcode

Behaviour:
- Opcodes: BEGIN 0x01, END 0x02, VERTEX 0x03, COLOR 0x04, MATRIXMODE 0x10, MULTMATRIX 0x11, LOADID 0x12, LOADMATRIX 0x13, PUSH 0x14, POP 0x15, ROTATE 0x16, SCALE 0x17, TRANSLATE 0x18, VIEWPORT 0x19, FRUSTUM 0x1A.
- cmd_ready = (state==IDLE). A command is accepted on cmd_valid & cmd_ready in cycle T. cmd_valid outside IDLE is ignored; the upstream stage holds the command.
- Enables other than matrix_load_en are 1-cycle pulses. matrix_mode_out and matrix_mul_type hold their last value.
- Single-cycle ops:
  - BEGIN, END, FRUSTUM: cmd_done only.
  - MATRIXMODE: curr_mode <= imm[0].
  - LOADID, PUSH, POP: matrix_mode_out <= curr_mode and the enable pulses.
  - All of these pulse in T+1 with cmd_done in T+1; state stays IDLE, so back-to-back issue is allowed.
- MUL state (MULT/ROTATE/SCALE/TRANSLATE): T+1 matrix_mul_en=1, type=1, mode=curr_mode. Waits MUL4_LAT cycles; cmd_done at T+1+MUL4_LAT, then IDLE.
- VERTEX: VTX_MV → VTX_PJ → PDIV → IDLE.
  - VTX_MV: T+1 mul_en pulse with type=0, mode=0.
  - VTX_PJ: after MUL1_LAT, mul_en pulse with mode=1.
  - PDIV: after another MUL1_LAT, perspective_div_en pulse.
  - cmd_done PDIV_LAT cycles after that pulse, then IDLE.
- LOADMATRIX: matrix_load_en high for exactly LOAD_WORDS cycles from T+1. bram_addr_out = base + k*ADDR_STRIDE for k = 0..LOAD_WORDS-1, wrapping mod 2^ADDR_W. mode=curr_mode; cmd_done on the last load cycle.
- COLOR/VIEWPORT: RD_WAIT → RD_CAP.
  - T+1: bram_addr_out=base, bram_mux_sel=0.
  - Data is valid in T+2 and captured at the end of T+2. COLOR takes w0..w2 → red/green/blue; VIEWPORT takes w0..w3.
  - New values visible, with cmd_done, in T+3.
- Unknown opcode: accepted; err_illegal and cmd_done pulse in T+1; no other state changes.
- Wait counter width is $clog2(max latency + 1).
- Reset (any state, including mid-operation) forces:
  - state IDLE, all pulses 0, load_en 0, busy 0;
  - curr_mode, mode_out and mul_type 0;
  - bram_addr_out 0, mux_sel 0, color 0;
  - viewport {0x43700000, 0x43A00000, 0, 0} (240, 320, 0, 0).
- cmd_ready is 0 during reset.

Optional Feature:
GL_CMD_STATS_EN
- Defined: adds outputs vertex_count[31:0] (increments on each VERTEX cmd_done) and busy_cycles[31:0] (increments each cycle busy=1). Both are saturating and cleared by reset.
- Undefined: both ports remain and are tied to 0; no counter logic is built.

Decomposition:
- Package gl_cmd_pkg: opcode localparams, state enum, viewport/colour reset constants.
- Sub-module gl_wait_counter: load value, count down, 1-cycle expire pulse, synchronous clear. Instantiated once and reused by every wait state.

Test Plan:
- Reset then idle → cmd_ready=1; viewport width 0x43A00000, height 0x43700000; color 0.
- MATRIXMODE imm=1 then MULTMATRIX (MUL4_LAT=13) → mul_en pulse at T+1 with type=1, mode=1; cmd_done at T+14; cmd_ready low T+1..T+14.
- VERTEX (MUL1_LAT=3, PDIV_LAT=1) → mul_en at T+1 (mode 0) and T+4 (mode 1); pdiv pulse T+7; cmd_done T+8.
- LOADMATRIX base 0x100 → load_en high T+1..T+4; addresses 0x100, 0x104, 0x108, 0x10C; cmd_done T+4.
- COLOR with rd_data {_,3F800000,0,40000000} → red=0x40000000, green=0, blue=0x3F800000 at T+3; opcode 0x7F → err_illegal pulse, no output change.
- rst_n low mid-VERTEX → next cycle IDLE, no pulses; new PUSH accepted immediately.

Source files
------------

// File: rtl/gl_cmd_pkg.sv
// GL command sequencer shared definitions: opcodes, FSM states,
// reset constants and a small max helper for counter sizing.
package gl_cmd_pkg;

  localparam logic [7:0] OP_BEGIN      = 8'h01;
  localparam logic [7:0] OP_END        = 8'h02;
  localparam logic [7:0] OP_VERTEX     = 8'h03;
  localparam logic [7:0] OP_COLOR      = 8'h04;
  localparam logic [7:0] OP_MATRIXMODE = 8'h10;
  localparam logic [7:0] OP_MULTMATRIX = 8'h11;
  localparam logic [7:0] OP_LOADID     = 8'h12;
  localparam logic [7:0] OP_LOADMATRIX = 8'h13;
  localparam logic [7:0] OP_PUSH       = 8'h14;
  localparam logic [7:0] OP_POP        = 8'h15;
  localparam logic [7:0] OP_ROTATE     = 8'h16;
  localparam logic [7:0] OP_SCALE      = 8'h17;
  localparam logic [7:0] OP_TRANSLATE  = 8'h18;
  localparam logic [7:0] OP_VIEWPORT   = 8'h19;
  localparam logic [7:0] OP_FRUSTUM    = 8'h1A;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MUL_W,
    S_VTX_MV,
    S_VTX_PJ,
    S_PDIV,
    S_DONE,
    S_LOAD,
    S_RD_WAIT,
    S_RD_CAP
  } state_t;

  // 320x240 default viewport as IEEE-754 singles
  localparam logic [31:0] VP_X_RST = 32'h0000_0000;
  localparam logic [31:0] VP_Y_RST = 32'h0000_0000;
  localparam logic [31:0] VP_W_RST = 32'h43A0_0000;
  localparam logic [31:0] VP_H_RST = 32'h4370_0000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gl_wait_counter.sv
// Down-counter shared by all sequencer wait states.
// Ports: clk, i_clr (sync clear), i_load/i_val (load), o_count, o_expire (count==1).
module gl_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_count,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // loaded with L at the end of cycle T, expires in cycle T+L
  assign o_expire = (r_cnt == W'(1));
  assign o_count  = r_cnt;

endmodule

// File: rtl/gl_cmd_sequencer.sv
// GL command sequencer: handshakes opcodes in, pulses matrix/BRAM enables.
// Ports: cmd handshake, BRAM read path, matrix enables, status; GL_CMD_STATS_EN adds counters.
module gl_cmd_sequencer
  import gl_cmd_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MUL4_LAT    = 13,
  parameter int MUL1_LAT    = 3,
  parameter int PDIV_LAT    = 1,
  parameter int LOAD_WORDS  = 4,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [7:0]          opcode,
  input  logic [22:0]         imm,
  input  logic [ADDR_W-1:0]   bram_addr_in,
  input  logic [4*DATA_W-1:0] bram_rd_data,
  output logic [ADDR_W-1:0]   bram_addr_out,
  output logic                bram_mux_sel,
  output logic [4*DATA_W-1:0] viewport,
  output logic [3*DATA_W-1:0] color,
  output logic                matrix_mode_out,
  output logic                matrix_mul_type,
  output logic                matrix_mul_en,
  output logic                matrix_load_en,
  output logic                matrix_load_id_en,
  output logic                push_en,
  output logic                pop_en,
  output logic                perspective_div_en,
  output logic                busy,
  output logic                cmd_done,
  output logic                err_illegal,
  output logic [31:0]         vertex_count,
  output logic [31:0]         busy_cycles
);

  localparam int MAXL = max2(max2(MUL4_LAT, MUL1_LAT),
                             max2(PDIV_LAT, LOAD_WORDS));
  localparam int CNT_W = $clog2(MAXL + 1);

  localparam logic [4*DATA_W-1:0] VP_RST = {
    DATA_W'(VP_H_RST), DATA_W'(VP_W_RST),
    DATA_W'(VP_Y_RST), DATA_W'(VP_X_RST)
  };

  state_t r_state, w_state;

  logic r_curr_mode, w_curr_mode;
  logic r_mode_out, w_mode_out;
  logic r_mul_type, w_mul_type;
  logic r_mul_en, w_mul_en;
  logic r_load_en, w_load_en;
  logic r_load_id_en, w_load_id_en;
  logic r_push_en, w_push_en;
  logic r_pop_en, w_pop_en;
  logic r_pdiv_en, w_pdiv_en;
  logic r_done, w_done;
  logic r_err, w_err;
  logic r_rd_vp, w_rd_vp;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [3*DATA_W-1:0] r_color, w_color;
  logic [4*DATA_W-1:0] r_vp, w_vp;

  logic w_clr;
  logic w_cnt_ld;
  logic [CNT_W-1:0] w_cnt_val;
  logic [CNT_W-1:0] w_cnt;
  logic w_expire;
  logic w_unused_imm;

  assign w_clr = ~rst_n;
  assign w_unused_imm = ^imm[22:1];

  gl_wait_counter #(
    .W (CNT_W)
  ) u_wait (
    .clk      (clk),
    .i_clr    (w_clr),
    .i_load   (w_cnt_ld),
    .i_val    (w_cnt_val),
    .o_count  (w_cnt),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state      = r_state;
    w_curr_mode  = r_curr_mode;
    w_mode_out   = r_mode_out;
    w_mul_type   = r_mul_type;
    w_mul_en     = 1'b0;
    w_load_en    = 1'b0;
    w_load_id_en = 1'b0;
    w_push_en    = 1'b0;
    w_pop_en     = 1'b0;
    w_pdiv_en    = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_rd_vp      = r_rd_vp;
    w_addr       = r_addr;
    w_color      = r_color;
    w_vp         = r_vp;
    w_cnt_ld     = 1'b0;
    w_cnt_val    = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (opcode)
            OP_BEGIN, OP_END, OP_FRUSTUM: begin
              w_done = 1'b1;
            end
            OP_MATRIXMODE: begin
              w_curr_mode = imm[0];
              w_done      = 1'b1;
            end
            OP_LOADID: begin
              w_mode_out   = r_curr_mode;
              w_load_id_en = 1'b1;
              w_done       = 1'b1;
            end
            OP_PUSH: begin
              w_mode_out = r_curr_mode;
              w_push_en  = 1'b1;
              w_done     = 1'b1;
            end
            OP_POP: begin
              w_mode_out = r_curr_mode;
              w_pop_en   = 1'b1;
              w_done     = 1'b1;
            end
            OP_MULTMATRIX, OP_ROTATE,
            OP_SCALE, OP_TRANSLATE: begin
              w_mul_en   = 1'b1;
              w_mul_type = 1'b1;
              w_mode_out = r_curr_mode;
              w_cnt_ld   = 1'b1;
              w_cnt_val  = CNT_W'(MUL4_LAT);
              w_state    = S_MUL_W;
            end
            OP_VERTEX: begin
              w_mul_en   = 1'b1;
              w_mul_type = 1'b0;
              w_mode_out = 1'b0;
              w_cnt_ld   = 1'b1;
              w_cnt_val  = CNT_W'(MUL1_LAT);
              w_state    = S_VTX_MV;
            end
            OP_LOADMATRIX: begin
              w_load_en  = 1'b1;
              w_addr     = bram_addr_in;
              w_mode_out = r_curr_mode;
              w_done     = (LOAD_WORDS == 1);
              w_cnt_ld   = 1'b1;
              w_cnt_val  = CNT_W'(LOAD_WORDS);
              w_state    = S_LOAD;
            end
            OP_COLOR: begin
              w_addr  = bram_addr_in;
              w_rd_vp = 1'b0;
              w_state = S_RD_WAIT;
            end
            OP_VIEWPORT: begin
              w_addr  = bram_addr_in;
              w_rd_vp = 1'b1;
              w_state = S_RD_WAIT;
            end
            default: begin
              w_err  = 1'b1;
              w_done = 1'b1;
            end
          endcase
        end
      end
      S_MUL_W: begin
        if (w_expire) begin
          w_done  = 1'b1;
          w_state = S_DONE;
        end
      end
      S_VTX_MV: begin
        if (w_expire) begin
          w_mul_en   = 1'b1;
          w_mode_out = 1'b1;
          w_cnt_ld   = 1'b1;
          w_cnt_val  = CNT_W'(MUL1_LAT);
          w_state    = S_VTX_PJ;
        end
      end
      S_VTX_PJ: begin
        if (w_expire) begin
          w_pdiv_en = 1'b1;
          w_cnt_ld  = 1'b1;
          w_cnt_val = CNT_W'(PDIV_LAT);
          w_state   = S_PDIV;
        end
      end
      S_PDIV: begin
        if (w_expire) begin
          w_done  = 1'b1;
          w_state = S_DONE;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      S_LOAD: begin
        // expire marks the last load cycle; done is registered
        // one cycle early so it lands on that cycle
        if (w_expire) begin
          w_state = S_IDLE;
        end else begin
          w_load_en = 1'b1;
          w_addr    = r_addr + ADDR_W'(ADDR_STRIDE);
          w_done    = (32'(w_cnt) == 32'd2);
        end
      end
      S_RD_WAIT: begin
        w_state = S_RD_CAP;
      end
      S_RD_CAP: begin
        if (r_rd_vp) begin
          w_vp = bram_rd_data;
        end else begin
          w_color = bram_rd_data[3*DATA_W-1:0];
        end
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_curr_mode  <= 1'b0;
      r_mode_out   <= 1'b0;
      r_mul_type   <= 1'b0;
      r_mul_en     <= 1'b0;
      r_load_en    <= 1'b0;
      r_load_id_en <= 1'b0;
      r_push_en    <= 1'b0;
      r_pop_en     <= 1'b0;
      r_pdiv_en    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_rd_vp      <= 1'b0;
      r_addr       <= '0;
      r_color      <= '0;
      r_vp         <= VP_RST;
    end else begin
      r_state      <= w_state;
      r_curr_mode  <= w_curr_mode;
      r_mode_out   <= w_mode_out;
      r_mul_type   <= w_mul_type;
      r_mul_en     <= w_mul_en;
      r_load_en    <= w_load_en;
      r_load_id_en <= w_load_id_en;
      r_push_en    <= w_push_en;
      r_pop_en     <= w_pop_en;
      r_pdiv_en    <= w_pdiv_en;
      r_done       <= w_done;
      r_err        <= w_err;
      r_rd_vp      <= w_rd_vp;
      r_addr       <= w_addr;
      r_color      <= w_color;
      r_vp         <= w_vp;
    end
  end

  assign cmd_ready          = rst_n && (r_state == S_IDLE);
  assign busy               = (r_state != S_IDLE);
  assign bram_addr_out      = r_addr;
  // the sequencer is the only BRAM address master in this block
  assign bram_mux_sel       = 1'b0;
  assign viewport           = r_vp;
  assign color              = r_color;
  assign matrix_mode_out    = r_mode_out;
  assign matrix_mul_type    = r_mul_type;
  assign matrix_mul_en      = r_mul_en;
  assign matrix_load_en     = r_load_en;
  assign matrix_load_id_en  = r_load_id_en;
  assign push_en            = r_push_en;
  assign pop_en             = r_pop_en;
  assign perspective_div_en = r_pdiv_en;
  assign cmd_done           = r_done;
  assign err_illegal        = r_err;

`ifdef GL_CMD_STATS_EN
  logic [31:0] r_vtx_cnt;
  logic [31:0] r_busy_cyc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vtx_cnt  <= '0;
      r_busy_cyc <= '0;
    end else begin
      // same edge that raises the VERTEX cmd_done
      if (r_state == S_PDIV && w_expire &&
          r_vtx_cnt != '1) begin
        r_vtx_cnt <= r_vtx_cnt + 32'd1;
      end
      if (busy && r_busy_cyc != '1) begin
        r_busy_cyc <= r_busy_cyc + 32'd1;
      end
    end
  end

  assign vertex_count = r_vtx_cnt;
  assign busy_cycles  = r_busy_cyc;
`else
  assign vertex_count = '0;
  assign busy_cycles  = '0;
`endif

endmodule

// File: tb/tb_gl_cmd_sequencer.sv
// Self-checking bench for gl_cmd_sequencer: directed steps then
// randomized commands against a cycle-schedule reference model.
module tb_gl_cmd_sequencer;

  localparam int MUL4   = 13;
  localparam int MUL1   = 3;
  localparam int PDIV   = 1;
  localparam int LW     = 4;
  localparam int STRIDE = 4;
  localparam logic [127:0] VP_RST =
    {32'h43700000, 32'h43A00000, 32'h0, 32'h0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   opcode;
  logic [22:0]  imm;
  logic [31:0]  bram_addr_in;
  logic [127:0] bram_rd_data;
  logic [31:0]  bram_addr_out;
  logic         bram_mux_sel;
  logic [127:0] viewport;
  logic [95:0]  color;
  logic         matrix_mode_out;
  logic         matrix_mul_type;
  logic         matrix_mul_en;
  logic         matrix_load_en;
  logic         matrix_load_id_en;
  logic         push_en;
  logic         pop_en;
  logic         perspective_div_en;
  logic         busy;
  logic         cmd_done;
  logic         err_illegal;
  logic [31:0]  vertex_count;
  logic [31:0]  busy_cycles;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic         m_cm;
  logic         m_mo;
  logic         m_mt;
  logic [95:0]  m_color;
  logic [127:0] m_vp;

  // BRAM model: returns rd_word at rd_base, a hash elsewhere
  logic [31:0]  rd_base = 32'h0;
  logic [127:0] rd_word = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bram_rd_data <= (bram_addr_out == rd_base) ? rd_word :
      {~bram_addr_out, bram_addr_out ^ 32'h5A5A5A5A,
       bram_addr_out + 32'd1, bram_addr_out ^ 32'hFFFF0000};
  end

  gl_cmd_sequencer #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MUL4_LAT    (MUL4),
    .MUL1_LAT    (MUL1),
    .PDIV_LAT    (PDIV),
    .LOAD_WORDS  (LW),
    .ADDR_STRIDE (STRIDE)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .opcode             (opcode),
    .imm                (imm),
    .bram_addr_in       (bram_addr_in),
    .bram_rd_data       (bram_rd_data),
    .bram_addr_out      (bram_addr_out),
    .bram_mux_sel       (bram_mux_sel),
    .viewport           (viewport),
    .color              (color),
    .matrix_mode_out    (matrix_mode_out),
    .matrix_mul_type    (matrix_mul_type),
    .matrix_mul_en      (matrix_mul_en),
    .matrix_load_en     (matrix_load_en),
    .matrix_load_id_en  (matrix_load_id_en),
    .push_en            (push_en),
    .pop_en             (pop_en),
    .perspective_div_en (perspective_div_en),
    .busy               (busy),
    .cmd_done           (cmd_done),
    .err_illegal        (err_illegal),
    .vertex_count       (vertex_count),
    .busy_cycles        (busy_cycles)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cm = 1'b0;
    m_mo = 1'b0;
    m_mt = 1'b0;
    m_color = '0;
    m_vp = VP_RST;
  endtask

  function automatic logic [9:0] flags();
    return {cmd_ready, busy, cmd_done, err_illegal,
            matrix_mul_en, perspective_div_en, matrix_load_en,
            matrix_load_id_en, push_en, pop_en};
  endfunction

  task automatic run_cmd(input logic [7:0] op, input logic [22:0] im,
                         input logic [31:0] base, input logic [127:0] rd);
    int dn;
    int bend;
    bit ill, is_mul, is_vtx, is_ld, is_rd;
    logic [9:0] ev;
    logic [95:0] n_color;
    logic [127:0] n_vp;
    logic n_cm, n_mo, n_mt;
    is_mul = (op == 8'h11 || op == 8'h16 || op == 8'h17 || op == 8'h18);
    is_vtx = (op == 8'h03);
    is_ld  = (op == 8'h13);
    is_rd  = (op == 8'h04 || op == 8'h19);
    ill = !((op >= 8'h01 && op <= 8'h04) || (op >= 8'h10 && op <= 8'h1A));
    dn = 1;
    bend = 0;
    if (is_mul) begin dn = 1 + MUL4; bend = dn; end
    if (is_vtx) begin dn = 1 + 2*MUL1 + PDIV; bend = dn; end
    if (is_ld) begin dn = LW; bend = LW; end
    if (is_rd) begin dn = 3; bend = 2; end
    n_cm = m_cm; n_mo = m_mo; n_mt = m_mt;
    n_color = m_color; n_vp = m_vp;
    if (op == 8'h10) n_cm = im[0];
    if (op == 8'h12 || op == 8'h14 || op == 8'h15 || is_mul || is_ld)
      n_mo = m_cm;
    if (is_mul) n_mt = 1'b1;
    if (is_vtx) begin n_mo = 1'b1; n_mt = 1'b0; end
    if (op == 8'h04) n_color = rd[95:0];
    if (op == 8'h19) n_vp = rd;
    rd_base = base;
    rd_word = rd;
    @(negedge clk);
    chk($sformatf("op%02h_ready_pre", op), cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    opcode = op;
    imm = im;
    bram_addr_in = base;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= dn + 2; k++) begin
      @(negedge clk);
      ev = {k > bend, k <= bend, k == dn, ill && k == 1,
            (is_mul && k == 1) || (is_vtx && (k == 1 || k == 1 + MUL1)),
            is_vtx && k == 1 + 2*MUL1, is_ld && k <= LW,
            op == 8'h12 && k == 1, op == 8'h14 && k == 1,
            op == 8'h15 && k == 1};
      chk($sformatf("op%02h_k%0d_flags", op, k), flags(), ev);
      if (is_mul && k == 1)
        chk("mul4_type_mode", {matrix_mul_type, matrix_mode_out}, {1'b1, m_cm});
      if (is_vtx && k == 1)
        chk("vtx_mv_type_mode", {matrix_mul_type, matrix_mode_out}, 2'b00);
      if (is_vtx && k == 1 + MUL1)
        chk("vtx_pj_type_mode", {matrix_mul_type, matrix_mode_out}, 2'b01);
      if (is_ld && k <= LW)
        chk($sformatf("load_addr_k%0d", k), {bram_addr_out, matrix_mode_out},
            {base + 32'(k - 1) * 32'(STRIDE), m_cm});
      if (is_rd && k == 1)
        chk("rd_addr_sel", {bram_addr_out, bram_mux_sel}, {base, 1'b0});
      if (is_rd && k == 2)
        chk("rd_old_vals", {viewport, color}, {m_vp, m_color});
      if (is_rd && k == 3)
        chk("rd_new_vals", {viewport, color}, {n_vp, n_color});
    end
    m_cm = n_cm; m_mo = n_mo; m_mt = n_mt;
    m_color = n_color; m_vp = n_vp;
    chk($sformatf("op%02h_state_after", op),
        {viewport, color, matrix_mode_out, matrix_mul_type},
        {m_vp, m_color, m_mo, m_mt});
  endtask

  logic [7:0] ops [17] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11,
                           8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                           8'h18, 8'h19, 8'h1A, 8'h7F, 8'h00};

  initial begin
    logic [7:0] op;
    logic [127:0] rd;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    opcode = 8'h0;
    imm = '0;
    bram_addr_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("ready_in_reset", cmd_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_flags", flags(), 10'b10_0000_0000);
    chk("reset_vp", viewport, VP_RST);
    chk("reset_color_misc",
        {color, bram_addr_out, bram_mux_sel, matrix_mode_out, matrix_mul_type},
        '0);
    chk("reset_stats", {vertex_count, busy_cycles}, 64'h0);

    run_cmd(8'h10, 23'h1, 32'h0, '0);
    run_cmd(8'h11, 23'h0, 32'h0, '0);
    run_cmd(8'h03, 23'h0, 32'h0, '0);
    run_cmd(8'h13, 23'h0, 32'h100, '0);
    run_cmd(8'h04, 23'h0, 32'h200,
            {32'hDEADBEEF, 32'h3F800000, 32'h0, 32'h40000000});
    chk("color_directed", color, {32'h3F800000, 32'h0, 32'h40000000});
    run_cmd(8'h7F, 23'h0, 32'h0, '0);
    run_cmd(8'h13, 23'h0, 32'hFFFFFFF8, '0);
    run_cmd(8'h19, 23'h0, 32'h40,
            {32'h43F00000, 32'h44200000, 32'h41200000, 32'h41A00000});

    // back-to-back single-cycle commands
    @(negedge clk);
    cmd_valid = 1'b1;
    opcode = 8'h14;
    @(posedge clk);
    #1;
    opcode = 8'h15;
    @(negedge clk);
    chk("b2b_push", flags(), 10'b10_1000_0010);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_pop", flags(), 10'b10_1000_0001);
    m_mo = m_cm;

    // reset in the middle of a VERTEX
    @(negedge clk);
    cmd_valid = 1'b1;
    opcode = 8'h03;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ready_mid_reset", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_k%0d", k), flags(), 10'b10_0000_0000);
    end
    chk("post_reset_state",
        {viewport, color, matrix_mode_out, matrix_mul_type}, {VP_RST, 98'h0});
    run_cmd(8'h14, 23'h0, 32'h0, '0);

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 16)];
      if ($urandom_range(0, 9) == 0) op = 8'($urandom);
      rd = {$urandom, $urandom, $urandom, $urandom};
      run_cmd(op, 23'($urandom), $urandom, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
